// File: rtl/ram_access_arbiter_if.sv
// rtl/ram_access_arbiter_if.sv - one requester's handshake to the RAM arbiter
// Signals:
//   req    requester -> arbiter  request, held with its fields until gnt
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  RAM word address
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  granted this cycle (combinational)
//   rvalid arbiter -> requester  read data valid, one-cycle pulse
//   rdata  arbiter -> requester  registered read data, held until the next read
interface ram_access_arbiter_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic                     req;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     gnt;
    logic                     rvalid;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - shares one single-port RAM between requesters A and B
// Ports:
//   clk        clock, all state on the rising edge
//   clr        synchronous active-high reset
//   a_port     requester A handshake (slave side)
//   b_port     requester B handshake (slave side)
//   ram_re     RAM read enable
//   ram_we     RAM write enable
//   ram_addr   RAM address (0 when idle)
//   ram_wdata  RAM write data (0 when idle)
//   ram_rdata  RAM combinational read data
//   init_done  high once the zero-fill sweep has finished, until the next clr
module ram_access_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    ram_access_arbiter_if.slave      a_port,
    ram_access_arbiter_if.slave      b_port,
    output logic                     ram_re,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     init_done
);

    localparam logic INIT_EN = (INIT_ON_RESET != 0);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};

    typedef enum logic {
        ST_INIT,
        ST_SERVE
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] init_cnt;
    logic                     last_grant_b;   // 1 = B was granted most recently
    logic                     serving;
    logic                     a_gnt;
    logic                     b_gnt;

    // On a tie the port that was not granted last wins; reset leaves B as
    // "last" so A takes the first tie.
    always_comb begin
        serving = (state == ST_SERVE) && !clr;
        a_gnt   = serving && a_port.req && (!b_port.req || last_grant_b);
        b_gnt   = serving && b_port.req && !a_gnt;
    end

    assign a_port.gnt = a_gnt;
    assign b_port.gnt = b_gnt;

    // RAM side: the sweep owns the RAM in INIT, otherwise the granted port.
    always_comb begin
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!clr) begin
            if (state == ST_INIT) begin
                ram_we   = 1'b1;
                ram_addr = init_cnt;
            end else if (a_gnt) begin
                ram_we    = a_port.we;
                ram_re    = !a_port.we;
                ram_addr  = a_port.addr;
                ram_wdata = a_port.we ? a_port.wdata : '0;
            end else if (b_gnt) begin
                ram_we    = b_port.we;
                ram_re    = !b_port.we;
                ram_addr  = b_port.addr;
                ram_wdata = b_port.we ? b_port.wdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= INIT_EN ? ST_INIT : ST_SERVE;
            init_cnt      <= '0;
            last_grant_b  <= 1'b1;
            a_port.rvalid <= 1'b0;
            b_port.rvalid <= 1'b0;
            a_port.rdata  <= '0;
            b_port.rdata  <= '0;
            init_done     <= !INIT_EN;
        end else begin
            a_port.rvalid <= a_gnt && !a_port.we;
            b_port.rvalid <= b_gnt && !b_port.we;
            if (a_gnt && !a_port.we) begin
                a_port.rdata <= ram_rdata;
            end
            if (b_gnt && !b_port.we) begin
                b_port.rdata <= ram_rdata;
            end
            if (a_gnt) begin
                last_grant_b <= 1'b0;
            end else if (b_gnt) begin
                last_grant_b <= 1'b1;
            end
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                // The last word is written at this edge, so SERVE and
                // init_done both start in the following cycle.
                if (init_cnt == LAST_ADDR) begin
                    state     <= ST_SERVE;
                    init_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic clr;
    logic preload;
    always #5 clk = ~clk;

    ram_access_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) a0 ();
    ram_access_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
    ram_access_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) a1 ();
    ram_access_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

    logic          ram_re0, ram_we0, init_done0;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_wdata0, ram_rdata0;
    logic          ram_re1, ram_we1, init_done1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_wdata1, ram_rdata1;

    ram_access_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1)) dut0 (
        .clk(clk), .clr(clr), .a_port(a0), .b_port(b0),
        .ram_re(ram_re0), .ram_we(ram_we0), .ram_addr(ram_addr0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0), .init_done(init_done0)
    );

    ram_access_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(0)) dut1 (
        .clk(clk), .clr(clr), .a_port(a1), .b_port(b1),
        .ram_re(ram_re1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .init_done(init_done1)
    );

    // Physical RAMs (sync write, combinational read), preloaded with garbage.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] garb0 [DEPTH];
    logic [DW-1:0] ram1_init [DEPTH];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem0[i] <= garb0[i];
                mem1[i] <= ram1_init[i];
            end
        end else begin
            if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
        end
    end
    assign ram_rdata0 = mem0[ram_addr0];
    assign ram_rdata1 = mem1[ram_addr1];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for dut0 once serving.
    logic [DW-1:0] refmem [DEPTH];
    logic          m_last_b;
    logic          m_pend_a, m_pend_b;
    logic [DW-1:0] m_exp_a, m_exp_b;
    logic          m_gnt_a, m_gnt_b;
    logic          m_ram_we, m_ram_re;
    logic [AW-1:0] m_ram_addr;
    logic [DW-1:0] m_ram_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_pend_a = 1'b0;
        m_pend_b = 1'b0;
        m_exp_a  = '0;
        m_exp_b  = '0;
    endtask

    // Applies one cycle of requests from dut0's ports to the model.
    task automatic model_step();
        int owner;   // 0 none, 1 A, 2 B
        if (a0.req && b0.req) owner = m_last_b ? 1 : 2;
        else if (a0.req)      owner = 1;
        else if (b0.req)      owner = 2;
        else                  owner = 0;
        m_gnt_a = (owner == 1);
        m_gnt_b = (owner == 2);
        m_ram_we = 1'b0; m_ram_re = 1'b0; m_ram_addr = '0; m_ram_wdata = '0;
        m_pend_a = 1'b0; m_pend_b = 1'b0;
        if (owner != 0) begin
            m_last_b   = (owner == 2);
            m_ram_addr = (owner == 1) ? a0.addr : b0.addr;
            if ((owner == 1) ? a0.we : b0.we) begin
                m_ram_we    = 1'b1;
                m_ram_wdata = (owner == 1) ? a0.wdata : b0.wdata;
                refmem[m_ram_addr] = m_ram_wdata;
            end else begin
                m_ram_re = 1'b1;
                if (owner == 1) begin m_pend_a = 1'b1; m_exp_a = refmem[m_ram_addr]; end
                else            begin m_pend_b = 1'b1; m_exp_b = refmem[m_ram_addr]; end
            end
        end
    endtask

    task automatic idle_inputs();
        a0.req = 0; a0.we = 0; a0.addr = '0; a0.wdata = '0;
        b0.req = 0; b0.we = 0; b0.addr = '0; b0.wdata = '0;
    endtask

    task automatic test_reset();
        a0.req = 1; b0.req = 1; b1.req = 1;
        #1;
        n_cmp++;
        if (a0.gnt !== 0 || b0.gnt !== 0 || b1.gnt !== 0 || ram_we0 !== 0 || ram_re0 !== 0 || ram_we1 !== 0 || ram_re1 !== 0) begin
            n_err++;
            $display("FAIL reset_no_grant gnt a0=%b b0=%b b1=%b we0=%b re0=%b we1=%b re1=%b expected all 0",
                     a0.gnt, b0.gnt, b1.gnt, ram_we0, ram_re0, ram_we1, ram_re1);
        end
        n_cmp++;
        if (a0.rvalid !== 0 || b0.rvalid !== 0 || a0.rdata !== 0 || b0.rdata !== 0) begin
            n_err++;
            $display("FAIL reset_read_regs rvalid=%b/%b rdata=%h/%h expected 0", a0.rvalid, b0.rvalid, a0.rdata, b0.rdata);
        end
        n_cmp++;
        if (init_done0 !== 1'b0 || init_done1 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_init_done got %b/%b expected 0/1", init_done0, init_done1);
        end
        a0.req = 0; b0.req = 0; b1.req = 0;
        model_reset();
    endtask

    task automatic test_mid_init_reset();
        clr = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (ram_we0 !== 1'b1 || ram_addr0 !== AW'(k) || init_done0 !== 1'b0) begin
                n_err++;
                $display("FAIL mid_init_sweep k=%0d we=%b addr=%0d done=%b expected 1/%0d/0", k, ram_we0, ram_addr0, init_done0, k);
            end
            if (k == 7) clr = 1;
            else tick();
        end
        #1;
        n_cmp++;
        if (ram_we0 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_init_clr_we got %b expected 0", ram_we0);
        end
        tick();
        clr = 0;
        model_reset();
    endtask

    task automatic test_init_sweep();
        a0.req = 1; a0.we = 0; a0.addr = 4'h3;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            n_cmp++;
            if (ram_we0 !== 1'b1 || ram_addr0 !== AW'(k) || ram_wdata0 !== '0 || a0.gnt !== 1'b0 || init_done0 !== 1'b0) begin
                n_err++;
                $display("FAIL init_sweep k=%0d we=%b addr=%0d wdata=%h gnt=%b done=%b expected 1/%0d/0/0/0",
                         k, ram_we0, ram_addr0, ram_wdata0, a0.gnt, init_done0, k);
            end
            tick();
        end
        for (int i = 0; i < DEPTH; i++) refmem[i] = '0;
        model_step();
        #1;
        n_cmp++;
        if (init_done0 !== 1'b1 || a0.gnt !== 1'b1) begin
            n_err++;
            $display("FAIL init_done_first_grant done=%b gnt=%b expected 1/1", init_done0, a0.gnt);
        end
        begin
            int nz = 0;
            for (int i = 0; i < DEPTH; i++) if (mem0[i] !== '0) nz++;
            n_cmp++;
            if (nz != 0) begin
                n_err++;
                $display("FAIL init_ram_zeroed nonzero_words=%0d expected 0", nz);
            end
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (a0.rvalid !== 1'b1 || a0.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL init_held_read rvalid=%b rdata=%h expected 1/0", a0.rvalid, a0.rdata);
        end
    endtask

    task automatic test_single_rw();
        a0.req = 1; a0.we = 1; a0.addr = 4'h5; a0.wdata = 32'hDEADBEEF;
        model_step();
        #1;
        n_cmp++;
        if (a0.gnt !== 1'b1 || ram_we0 !== 1'b1 || ram_addr0 !== 4'h5 || ram_wdata0 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rw_write gnt=%b we=%b addr=%h wdata=%h expected 1/1/5/deadbeef", a0.gnt, ram_we0, ram_addr0, ram_wdata0);
        end
        tick();
        a0.we = 0; a0.wdata = '0;
        model_step();
        #1;
        n_cmp++;
        if (a0.gnt !== 1'b1 || ram_re0 !== 1'b1 || ram_we0 !== 1'b0 || a0.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_read gnt=%b re=%b we=%b rvalid=%b expected 1/1/0/0", a0.gnt, ram_re0, ram_we0, a0.rvalid);
        end
        tick();
        idle_inputs();
        model_step();
        n_cmp++;
        if (a0.rvalid !== 1'b1 || a0.rdata !== 32'hDEADBEEF || b0.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_rdata rvalid=%b rdata=%h b_rvalid=%b expected 1/deadbeef/0", a0.rvalid, a0.rdata, b0.rvalid);
        end
        tick();
        n_cmp++;
        if (a0.rvalid !== 1'b0 || a0.rdata !== 32'hDEADBEEF || ram_we0 !== 0 || ram_re0 !== 0 || ram_addr0 !== 0 || ram_wdata0 !== 0) begin
            n_err++;
            $display("FAIL rw_idle rvalid=%b rdata=%h we=%b re=%b addr=%h wdata=%h expected 0/deadbeef/0/0/0/0",
                     a0.rvalid, a0.rdata, ram_we0, ram_re0, ram_addr0, ram_wdata0);
        end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 3; i++) begin
            b0.req = 1; b0.we = 1; b0.addr = AW'(i + 8); b0.wdata = $urandom;
            model_step();
            #1;
            n_cmp++;
            if (b0.gnt !== 1'b1 || a0.gnt !== 1'b0) begin
                n_err++;
                $display("FAIL fair_b_alone i=%0d gnt a=%b b=%b expected 0/1", i, a0.gnt, b0.gnt);
            end
            tick();
        end
        a0.req = 1; a0.we = 0; a0.addr = 4'h8;
        b0.we = 0; b0.addr = 4'h9;
        model_step();
        #1;
        n_cmp++;
        if (a0.gnt !== 1'b1 || b0.gnt !== 1'b0) begin
            n_err++;
            $display("FAIL fair_a_first gnt a=%b b=%b expected 1/0", a0.gnt, b0.gnt);
        end
        tick();
        idle_inputs();
        model_step();
        n_cmp++;
        if (a0.rvalid !== 1'b1 || a0.rdata !== m_exp_a) begin
            n_err++;
            $display("FAIL fair_a_rdata rvalid=%b rdata=%h expected 1/%h", a0.rvalid, a0.rdata, m_exp_a);
        end
        tick();
    endtask

    task automatic test_contention();
        logic pa, pb;
        b0.req = 1; b0.we = 1; b0.addr = 4'h2; b0.wdata = 32'h1234_5678;
        model_step();
        tick();
        for (int i = 0; i < 6; i++) begin
            a0.req = 1; a0.we = 0; a0.addr = AW'($urandom);
            b0.req = 1; b0.we = 0; b0.addr = AW'($urandom);
            pa = m_pend_a; pb = m_pend_b;
            n_cmp++;
            if (a0.rvalid !== pa || b0.rvalid !== pb || (pa && a0.rdata !== m_exp_a) || (pb && b0.rdata !== m_exp_b)) begin
                n_err++;
                $display("FAIL contend_rvalid i=%0d rvalid=%b/%b rdata=%h/%h expected %b/%b %h/%h",
                         i, a0.rvalid, b0.rvalid, a0.rdata, b0.rdata, pa, pb, m_exp_a, m_exp_b);
            end
            model_step();
            #1;
            n_cmp++;
            if (a0.gnt !== (i % 2 == 0) || b0.gnt !== (i % 2 == 1) || ram_addr0 !== m_ram_addr) begin
                n_err++;
                $display("FAIL contend_order i=%0d gnt a=%b b=%b addr=%h expected %b/%b %h",
                         i, a0.gnt, b0.gnt, ram_addr0, (i % 2 == 0), (i % 2 == 1), m_ram_addr);
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (b0.rvalid !== 1'b1 || a0.rvalid !== 1'b0 || b0.rdata !== m_exp_b) begin
            n_err++;
            $display("FAIL contend_last rvalid=%b/%b rdata=%h expected 0/1 %h", a0.rvalid, b0.rvalid, b0.rdata, m_exp_b);
        end
        model_step();
        tick();
    endtask

    task automatic test_random();
        logic a_hold = 0, b_hold = 0;
        int bad_reg = 0, bad_comb = 0;
        for (int c = 0; c < 400; c++) begin
            if (a0.rvalid !== m_pend_a || a0.rdata !== m_exp_a || b0.rvalid !== m_pend_b || b0.rdata !== m_exp_b) begin
                if (bad_reg < 5)
                    $display("FAIL rand_read c=%0d rvalid=%b/%b rdata=%h/%h expected %b/%b %h/%h",
                             c, a0.rvalid, b0.rvalid, a0.rdata, b0.rdata, m_pend_a, m_pend_b, m_exp_a, m_exp_b);
                bad_reg++;
            end
            if (!a_hold || $urandom_range(0, 9) == 0) begin
                a0.req = ($urandom_range(0, 9) < 6); a0.we = $urandom; a0.addr = AW'($urandom); a0.wdata = $urandom;
            end
            if (!b_hold || $urandom_range(0, 9) == 0) begin
                b0.req = ($urandom_range(0, 9) < 6); b0.we = $urandom; b0.addr = AW'($urandom); b0.wdata = $urandom;
            end
            model_step();
            #1;
            if (a0.gnt !== m_gnt_a || b0.gnt !== m_gnt_b || ram_we0 !== m_ram_we || ram_re0 !== m_ram_re ||
                ram_addr0 !== m_ram_addr || ram_wdata0 !== m_ram_wdata) begin
                if (bad_comb < 5)
                    $display("FAIL rand_access c=%0d gnt=%b/%b we=%b re=%b addr=%h wdata=%h expected %b/%b %b %b %h %h",
                             c, a0.gnt, b0.gnt, ram_we0, ram_re0, ram_addr0, ram_wdata0,
                             m_gnt_a, m_gnt_b, m_ram_we, m_ram_re, m_ram_addr, m_ram_wdata);
                bad_comb++;
            end
            a_hold = a0.req && !m_gnt_a;
            b_hold = b0.req && !m_gnt_b;
            tick();
        end
        n_cmp++;
        if (bad_reg != 0) n_err++;
        n_cmp++;
        if (bad_comb != 0) n_err++;
        idle_inputs();
    endtask

    task automatic test_no_init();
        clr = 1;
        tick();
        clr = 0;
        b1.req = 1; b1.we = 0; b1.addr = 4'h3; b1.wdata = '0;
        #1;
        n_cmp++;
        if (b1.gnt !== 1'b1 || ram_re1 !== 1'b1 || ram_addr1 !== 4'h3 || init_done1 !== 1'b1) begin
            n_err++;
            $display("FAIL noinit_grant gnt=%b re=%b addr=%h done=%b expected 1/1/3/1", b1.gnt, ram_re1, ram_addr1, init_done1);
        end
        tick();
        b1.req = 0;
        n_cmp++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== ram1_init[3] || a1.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL noinit_rdata rvalid=%b rdata=%h a_rvalid=%b expected 1/%h/0", b1.rvalid, b1.rdata, a1.rvalid, ram1_init[3]);
        end
        tick();
    endtask

    initial begin
        clr = 1;
        preload = 1;
        for (int i = 0; i < DEPTH; i++) begin
            garb0[i]     = $urandom | 32'h1;
            ram1_init[i] = 32'hA500_0000 | 32'(i);
        end
        idle_inputs();
        a1.req = 0; a1.we = 0; a1.addr = '0; a1.wdata = '0;
        b1.req = 0; b1.we = 0; b1.addr = '0; b1.wdata = '0;
        tick();
        tick();
        preload = 0;
        tick();
        test_reset();
        test_mid_init_reset();
        test_init_sweep();
        test_single_rw();
        test_fairness();
        test_contention();
        test_random();
        test_no_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
